// File: rtl/design_20_rsp_buf.sv
// Result buffer: captures upstream y/valid pulses into a DEPTH-entry FIFO and re-presents them on ready/valid.
// Optional per-entry parity storage is enabled by defining DESIGN_20_RSP_BUF_PARITY_EN.
module design_20_rsp_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W-1:0]               in_y_i,
    input  logic                       in_valid_i,
    input  logic                       clr_i,
    output logic [W-1:0]               out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       out_par_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       ovf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
`ifdef DESIGN_20_RSP_BUF_PARITY_EN
    localparam int EW = W + 1;
`else
    localparam int EW = W;
`endif

    // Handshake: a head entry transfers on any rising edge where out_valid_o && out_ready_i.
    // out_valid_o never depends on out_ready_i, and out_data_o is stable while valid && !ready.

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;

    logic          pop;
    logic          push;
    logic          drop;
    logic          is_full;
    logic          not_empty;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] head_word;

    // Status is decoded from the occupancy register only, so no input reaches an output combinationally.
    assign is_full   = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);

    assign pop  = not_empty && out_ready_i && !clr_i;
    assign push = in_valid_i && (!is_full || pop) && !clr_i;
    assign drop = in_valid_i && is_full && !pop && !clr_i;

`ifdef DESIGN_20_RSP_BUF_PARITY_EN
    assign wr_word = {^in_y_i, in_y_i};
`else
    assign wr_word = in_y_i;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; stale contents are never visible because out_valid_o gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign head_word   = mem_q[rd_ptr_q];
    assign out_data_o  = head_word[W-1:0];
    assign out_valid_o = not_empty;
    assign count_o     = count_q;
    assign full_o      = is_full;
    assign ovf_o       = ovf_q;

`ifdef DESIGN_20_RSP_BUF_PARITY_EN
    assign out_par_o = not_empty && head_word[W];
`else
    assign out_par_o = 1'b0;
`endif

endmodule

// File: tb/tb_design_20_rsp_buf.sv
// Directed bench for design_20_rsp_buf (W=8, DEPTH=4); checks use immediate assertions.
module tb_design_20_rsp_buf;
    logic       clk;
    logic       rst_n;
    logic [7:0] in_y;
    logic       in_valid;
    logic       clr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_par;
    logic [2:0] count;
    logic       full;
    logic       ovf;

    int vectors;
    int miscompares;

    design_20_rsp_buf #(.W(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_y_i      (in_y),
        .in_valid_i  (in_valid),
        .clr_i       (clr),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_par_o   (out_par),
        .count_o     (count),
        .full_o      (full),
        .ovf_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_par(input logic [7:0] v);
`ifdef DESIGN_20_RSP_BUF_PARITY_EN
        return ^v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        in_y     = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        in_y      = '0;
        in_valid  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_par", out_par, 0);

        // Three pushes with a stalled consumer, then drain
        push(8'h11);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 8'h11);
        push(8'h22);
        push(8'h33);
        chk("three_count", count, 3);
        chk("three_head", out_data, 8'h11);
        step();
        chk("three_hold", out_data, 8'h11);
        out_ready = 1'b1;
        chk("pop0_data", out_data, 8'h11);
        step();
        chk("pop1_data", out_data, 8'h22);
        chk("pop1_count", count, 2);
        step();
        chk("pop2_data", out_data, 8'h33);
        chk("pop2_count", count, 1);
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_count", count, 0);
        out_ready = 1'b0;

        // Overflow: five pushes into four entries
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        chk("fill_ovf", ovf, 0);
        push(8'hA4);
        chk("drop_ovf", ovf, 1);
        chk("drop_count", count, 4);
        chk("drop_head", out_data, 8'hA0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_data", out_data, 8'hA0 + 8'(i));
            step();
        end
        chk("ovf_drain_valid", out_valid, 0);
        chk("ovf_sticky", ovf, 1);
        out_ready = 1'b0;
        step();
        chk("ovf_sticky2", ovf, 1);

        // clr beats a push that would otherwise land; no ovf from it
        push(8'h5A);
        in_y     = 8'hEE;
        in_valid = 1'b1;
        clr      = 1'b1;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_ovf", ovf, 0);
        chk("clr_count", count, 0);
        chk("clr_valid", out_valid, 0);

        // Full buffer pushes and pops in the same cycle
        for (int i = 1; i < 5; i++) push(8'hB0 + 8'(i));
        chk("b_full", full, 1);
        in_y      = 8'hB5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pp_count", count, 4);
        chk("pp_ovf", ovf, 0);
        chk("pp_full", full, 1);
        for (int i = 2; i < 6; i++) begin
            chk("pp_drain_data", out_data, 8'hB0 + 8'(i));
            step();
        end
        chk("pp_drain_valid", out_valid, 0);

        // Streaming with pointer wrap
        for (int i = 0; i < 16; i++) begin
            in_y     = 8'(i);
            in_valid = 1'b1;
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, 32'(i));
            chk("stream_count", count, 1);
            chk("stream_par", out_par, exp_par(8'(i)));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_count", count, 0);
        chk("stream_ovf", ovf, 0);
        out_ready = 1'b0;

        // Parity bit follows the head entry
        push(8'h07);
        push(8'h03);
        chk("par_first", out_par, exp_par(8'h07));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("par_second_data", out_data, 8'h03);
        chk("par_second", out_par, exp_par(8'h03));

        // Asynchronous reset mid-stream empties the buffer at once
        push(8'h44);
        chk("pre_rst_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_par", out_par, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
